// File: rtl/mtm_alu_serializer.sv
// ALU result serialiser: sends C/CTL as 11-bit frames on an idle-high line (optional inter-frame gap: MTM_SER_GAP_EN).
// Latency: first start bit the cycle after accept; done at accept + 55*BIT_CYCLES+1 (error: 11*BIT_CYCLES+1).
// Backpressure: in_ready is low from accept until the DONE cycle; in_valid seen while in_ready=0 is dropped.
module mtm_alu_serializer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] C,
    input  logic [7:0]  CTL,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sout,
    output logic        done
);

    localparam logic [7:0] BC_LAST = 8'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TYPE,
        S_DATA,
        S_STOP,
`ifdef MTM_SER_GAP_EN
        S_GAP,
`endif
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] c_q;
    logic [7:0]  ctl_q;
    logic [7:0]  shreg;
    logic [7:0]  bit_cnt;
    logic [2:0]  bit_idx;
    logic [2:0]  frame_cnt;
    logic [7:0]  frame_byte;
    logic        accept;
    logic        bit_end;

    assign accept  = in_valid && in_ready;
    assign bit_end = (bit_cnt == BC_LAST);

    // Frame 4 is always the CTL frame; error packets jump straight to it.
    always_comb begin
        frame_byte = ctl_q;
        case (frame_cnt)
            3'd0:    frame_byte = c_q[31:24];
            3'd1:    frame_byte = c_q[23:16];
            3'd2:    frame_byte = c_q[15:8];
            3'd3:    frame_byte = c_q[7:0];
            default: frame_byte = ctl_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            c_q       <= '0;
            ctl_q     <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            frame_cnt <= '0;
            in_ready  <= 1'b1;
            sout      <= 1'b1;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        c_q       <= C;
                        ctl_q     <= CTL;
                        frame_cnt <= CTL[7] ? 3'd4 : 3'd0;
                        bit_cnt   <= '0;
                        in_ready  <= 1'b0;
                        sout      <= 1'b0;
                        state     <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        sout    <= (frame_cnt == 3'd4);
                        state   <= S_TYPE;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                S_TYPE: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        sout    <= frame_byte[7];
                        shreg   <= {frame_byte[6:0], 1'b0};
                        bit_idx <= 3'd7;
                        state   <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd0) begin
                            sout  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            sout    <= shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (frame_cnt == 3'd4) begin
                            frame_cnt <= '0;
                            done      <= 1'b1;
                            in_ready  <= 1'b1;
                            sout      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            frame_cnt <= frame_cnt + 3'd1;
`ifdef MTM_SER_GAP_EN
                            sout      <= 1'b1;
                            state     <= S_GAP;
`else
                            sout      <= 1'b0;
                            state     <= S_START;
`endif
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
`ifdef MTM_SER_GAP_EN
                S_GAP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        sout    <= 1'b0;
                        state   <= S_START;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
`endif
                default: begin
                    sout  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: one instance at BIT_CYCLES=1, one at BIT_CYCLES=4.
module tb_mtm_alu_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_drv;
    logic [7:0]  ctl_drv;
    logic        v_drv;
    bit          sel;
    logic        in_valid1, in_valid4, in_ready1, in_ready4;
    logic        sout1, sout4, done1, done4;
    logic        sout_s, ready_s, done_s;

    always #5 clk = ~clk;

    assign in_valid1 = v_drv & ~sel;
    assign in_valid4 = v_drv & sel;
    assign sout_s    = sel ? sout4 : sout1;
    assign ready_s   = sel ? in_ready4 : in_ready1;
    assign done_s    = sel ? done4 : done1;

    mtm_alu_serializer #(.BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .C(c_drv), .CTL(ctl_drv), .in_valid(in_valid1),
        .in_ready(in_ready1), .sout(sout1), .done(done1)
    );

    mtm_alu_serializer #(.BIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .C(c_drv), .CTL(ctl_drv), .in_valid(in_valid4),
        .in_ready(in_ready4), .sout(sout4), .done(done4)
    );

    typedef struct {
        logic [31:0]      c;
        logic [7:0]       ctl;
        int               bc;
        int               nfr;
        logic [4:0][10:0] fr;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   rdy_bad;
    logic cap[$];
    vec_t tbl[4];
    vec_t v_b2b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] c, input logic [7:0] ctl, input int bc,
                                input int nfr, input logic [10:0] f0, input logic [10:0] f1,
                                input logic [10:0] f2, input logic [10:0] f3, input logic [10:0] f4);
        vec_t r;
        r.c = c; r.ctl = ctl; r.bc = bc; r.nfr = nfr;
        r.fr[0] = f0; r.fr[1] = f1; r.fr[2] = f2; r.fr[3] = f3; r.fr[4] = f4;
        return r;
    endfunction

    // Starts in the cycle after accept; returns in the cycle where done is seen.
    task automatic capture(output int lat);
        lat = 0;
        rdy_bad = 0;
        cap.delete();
        for (int k = 1; k <= 2000; k++) begin
            if (done_s === 1'b1) begin
                lat = k;
                break;
            end
            if (ready_s !== 1'b0) rdy_bad++;
            cap.push_back(sout_s);
            @(posedge clk); #1;
        end
        chk("done_seen", 64'(lat > 0), 64'd1);
    endtask

    task automatic check_pkt(input vec_t v, input int lat);
        int   gaps;
        int   len;
        int   unstable;
        int   pos;
        logic b;
        logic [10:0] f;
        logic bits[$];
        gaps = 0;
`ifdef MTM_SER_GAP_EN
        gaps = v.nfr - 1;
`endif
        len = v.nfr * 11 + gaps;
        chk($sformatf("len_%h", v.c), 64'(cap.size()), 64'(len * v.bc));
        chk($sformatf("latency_%h", v.c), 64'(lat), 64'(len * v.bc + 1));
        chk($sformatf("in_ready_low_%h", v.c), 64'(rdy_bad), 64'd0);
        if (cap.size() == len * v.bc) begin
            unstable = 0;
            for (int k = 0; k < len; k++) begin
                b = cap[k * v.bc];
                for (int j = 0; j < v.bc; j++)
                    if (cap[k * v.bc + j] !== b) unstable++;
                bits.push_back(b);
            end
            chk($sformatf("bit_stable_%h", v.c), 64'(unstable), 64'd0);
            pos = 0;
            for (int i = 0; i < v.nfr; i++) begin
                f = '0;
                for (int j = 0; j < 11; j++) f = {f[9:0], bits[pos + j]};
                chk($sformatf("frame%0d_%h", i, v.c), 64'(f), 64'(v.fr[i]));
                pos += 11;
`ifdef MTM_SER_GAP_EN
                if (i < v.nfr - 1) begin
                    chk($sformatf("gap%0d_%h", i, v.c), 64'(bits[pos]), 64'd1);
                    pos++;
                end
`endif
            end
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 500 && ready_s !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        chk("ready_wait", 64'(ready_s), 64'd1);
    endtask

    task automatic run_pkt(input vec_t v);
        int lat;
        sel = (v.bc == 4);
        wait_ready();
        c_drv = v.c; ctl_drv = v.ctl; v_drv = 1'b1;
        @(posedge clk); #1;
        v_drv = 1'b0; c_drv = ~v.c; ctl_drv = ~v.ctl;
        capture(lat);
        check_pkt(v, lat);
    endtask

    initial begin
        int lat;
        int bad;
        rst = 1'b1; v_drv = 1'b0; sel = 1'b0; c_drv = '0; ctl_drv = '0;

        tbl[0] = mk(32'h12345678, 8'h0E, 1, 5, 11'b0_0_00010010_1, 11'b0_0_00110100_1,
                    11'b0_0_01010110_1, 11'b0_0_01111000_1, 11'b0_1_00001110_1);
        tbl[1] = mk(32'hFFFFFFFF, 8'hC9, 1, 1, 11'b0_1_11001001_1, 11'h0, 11'h0, 11'h0, 11'h0);
        tbl[2] = mk(32'hA5A5A5A5, 8'h00, 1, 5, 11'b0_0_10100101_1, 11'b0_0_10100101_1,
                    11'b0_0_10100101_1, 11'b0_0_10100101_1, 11'b0_1_00000000_1);
        tbl[3] = mk(32'h00000000, 8'h02, 4, 5, 11'b0_0_00000000_1, 11'b0_0_00000000_1,
                    11'b0_0_00000000_1, 11'b0_0_00000000_1, 11'b0_1_00000010_1);
        v_b2b  = mk(32'h0F0F0F0F, 8'h01, 1, 5, 11'b0_0_00001111_1, 11'b0_0_00001111_1,
                    11'b0_0_00001111_1, 11'b0_0_00001111_1, 11'b0_1_00000001_1);

        #1;
        chk("rst_sout1", 64'(sout1), 64'd1);
        chk("rst_ready1", 64'(in_ready1), 64'd1);
        chk("rst_done1", 64'(done1), 64'd0);
        chk("rst_sout4", 64'(sout4), 64'd1);
        chk("rst_ready4", 64'(in_ready4), 64'd1);
        chk("rst_done4", 64'(done4), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_pkt(tbl[i]);

        // Back-to-back: in_valid held through DONE, C changed mid-packet.
        sel = 1'b0;
        wait_ready();
        c_drv = tbl[2].c; ctl_drv = tbl[2].ctl; v_drv = 1'b1;
        @(posedge clk); #1;
        c_drv = v_b2b.c; ctl_drv = v_b2b.ctl;
        capture(lat);
        check_pkt(tbl[2], lat);
        chk("b2b_ready_in_done", 64'(ready_s), 64'd1);
        @(posedge clk); #1;
        v_drv = 1'b0;
        chk("b2b_start_after_done", 64'(sout_s), 64'd0);
        capture(lat);
        check_pkt(v_b2b, lat);

        // Reset during frame 3, payload bit 5 (a 0 bit of 0x56).
        sel = 1'b0;
        wait_ready();
        c_drv = tbl[0].c; ctl_drv = tbl[0].ctl; v_drv = 1'b1;
        @(posedge clk); #1;
        v_drv = 1'b0;
        repeat (26) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_bit", 64'(sout1), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_sout", 64'(sout1), 64'd1);
        chk("mid_rst_ready", 64'(in_ready1), 64'd1);
        chk("mid_rst_done", 64'(done1), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (done1 !== 1'b0 || sout1 !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk("post_rst_quiet", 64'(bad), 64'd0);
        run_pkt(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
